// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus types and sizes for the bus mux arbiter
package cpu_bus_pkg;

   localparam int NREQ  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

   typedef logic [SEL_W-1:0] bus_sel_t;

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// rtl/mux_bus_arbiter_if.sv - request/grant/select bundle between bus sources and the arbiter
interface mux_bus_arbiter_if;
   import cpu_bus_pkg::*;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   bus_sel_t        sel;
   logic            busy;

   // arbiter side
   modport master (input req, output gnt, output sel, output busy);
   // bus-source side
   modport slave (output req, input gnt, input sel, input busy);

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - round-robin pick: first set request at or after ptr, wrapping 7->0
module rr_pick8
   import cpu_bus_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  bus_sel_t        ptr,
   output logic            found,
   output bus_sel_t        idx
);

   logic [NREQ-1:0] rot;
   bus_sel_t        off;

   // rotate so that bit 0 of rot is req[ptr]
   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[bus_sel_t'(ptr + bus_sel_t'(i))];
      end
   end

   // priority-encode the lowest set bit of the rotated vector
   always_comb begin
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) off = bus_sel_t'(i);
      end
   end

   assign found = |req;
   // unrotate; 3-bit addition wraps naturally
   assign idx   = bus_sel_t'(ptr + off);

endmodule

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin, burst-bounded owner of the shared 8-to-1 bus mux
module mux_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int MAX_HOLD = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   mux_bus_arbiter_if.master bus
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_t      state;
   bus_sel_t        rr_ptr;
   logic [HW-1:0]   hold_cnt;
   logic [NREQ-1:0] gnt_q;
   bus_sel_t        sel_q;
   logic            busy_q;

   logic            rel;
   bus_sel_t        next_ptr;
   bus_sel_t        pick_ptr;
   logic            found;
   bus_sel_t        idx;

   // owner gives up the bus when it stops asking or its burst is spent
   assign rel      = (state == ARB_OWN) && (!bus.req[sel_q] || (hold_cnt == HOLD_LAST));
   assign next_ptr = bus_sel_t'(sel_q + 1'b1);
   // on release, search from just past the owner so the handoff is fair this very cycle
   assign pick_ptr = rel ? next_ptr : rr_ptr;

   rr_pick8 u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (idx)
   );

   // FSM, rotation pointer, tenure counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         gnt_q    <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (found) begin
                  gnt_q    <= NREQ'(1) << idx;
                  sel_q    <= idx;
                  busy_q   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= ARB_OWN;
               end
            end
            default: begin
               if (!rel) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  rr_ptr <= next_ptr;
                  if (found) begin
                     gnt_q    <= NREQ'(1) << idx;
                     sel_q    <= idx;
                     hold_cnt <= '0;
                  end else begin
                     // sel keeps its value so the mux output stays stable while idle
                     gnt_q    <= '0;
                     busy_q   <= 1'b0;
                     hold_cnt <= '0;
                     state    <= ARB_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - self-checking bench for mux_bus_arbiter against a tenure-level model
module tb_mux_bus_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   // reference model state: who owns the bus, how many cycles it has held it, where search starts
   int   m_owner;
   int   m_tenure;
   int   m_ptr;
   int   m_sel;

   mux_bus_arbiter_if bus ();

   mux_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int search(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] exp_gnt();
      logic [7:0] g;
      g = 8'h00;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // advance the model by one clock edge given the inputs sampled at that edge
   task automatic model_step(input logic [7:0] r, input logic rn);
      int w;
      if (!rn) begin
         m_owner  = -1;
         m_tenure = 0;
         m_ptr    = 0;
         m_sel    = 0;
      end else if (m_owner < 0) begin
         w = search(r, m_ptr);
         if (w >= 0) begin
            m_owner  = w;
            m_sel    = w;
            m_tenure = 1;
         end
      end else if (!r[m_owner] || m_tenure == MAX_HOLD) begin
         m_ptr = (m_owner + 1) % 8;
         w     = search(r, m_ptr);
         m_owner  = w;
         m_tenure = (w >= 0) ? 1 : 0;
         if (w >= 0) m_sel = w;
      end else begin
         m_tenure++;
      end
   endtask

   // apply inputs, take one edge, then compare all outputs against the model
   task automatic cycle(input logic [7:0] r, input logic rn);
      logic [7:0] g;
      bus.req = r;
      rst_n   = rn;
      @(posedge clk);
      model_step(r, rn);
      #1;
      g = exp_gnt();
      check("gnt", 32'(bus.gnt), 32'(g));
      check("sel", 32'(bus.sel), 32'(m_sel));
      check("busy", 32'(bus.busy), 32'(g != 8'h00));
      check("onehot", 32'($onehot0(bus.gnt)), 32'(1));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_owner  = -1;
      m_tenure = 0;
      m_ptr    = 0;
      m_sel    = 0;
      bus.req  = 8'h00;
      rst_n    = 1'b0;

      // 1: reset held with every source requesting
      cycle(8'hFF, 1'b0);
      cycle(8'hFF, 1'b0);
      check("t1_rst_gnt", 32'(bus.gnt), 32'h00);
      check("t1_rst_sel", 32'(bus.sel), 32'd0);
      cycle(8'hFF, 1'b1);
      check("t1_first_gnt", 32'(bus.gnt), 32'h01);

      // 2: single requester, then drop
      cycle(8'h00, 1'b0);
      cycle(8'h20, 1'b1);
      check("t2_gnt", 32'(bus.gnt), 32'h20);
      check("t2_sel", 32'(bus.sel), 32'd5);
      cycle(8'h00, 1'b1);
      check("t2_drop_busy", 32'(bus.busy), 32'd0);
      check("t2_drop_sel", 32'(bus.sel), 32'd5);

      // 3: burst limit alternates two persistent requesters with no idle gap
      cycle(8'h00, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cycle(8'h03, 1'b1);
         check("t3_seq", 32'(bus.gnt), (i < 4 || i >= 8) ? 32'h01 : 32'h02);
      end

      // 4: pointer wraps past 7 back to 0
      cycle(8'h00, 1'b0);
      cycle(8'h80, 1'b1);
      for (int i = 0; i < MAX_HOLD; i++) cycle(8'h81, 1'b1);
      check("t4_wrap", 32'(bus.gnt), 32'h01);

      // 5: lone persistent requester keeps the bus across burst boundaries
      cycle(8'h00, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cycle(8'h10, 1'b1);
         check("t5_hold", 32'(bus.gnt), 32'h10);
      end

      // 6: reset mid-tenure, then priority restarts from index 0
      cycle(8'h00, 1'b0);
      cycle(8'h08, 1'b1);
      cycle(8'h08, 1'b1);
      cycle(8'h08, 1'b1);
      cycle(8'h08, 1'b0);
      check("t6_rst_gnt", 32'(bus.gnt), 32'h00);
      check("t6_rst_sel", 32'(bus.sel), 32'd0);
      cycle(8'h18, 1'b1);
      check("t6_regrant", 32'(bus.gnt), 32'h08);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         logic [7:0] r;
         r = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         cycle(r, ($urandom_range(0, 60) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
